// File: rtl/rr_decode_scheduler.sv
// Round-robin scheduler sharing one 4-to-16 one-hot decoder among 16 requesters.
// Latency: a request seen in IDLE is granted one edge later; all outputs are registered.
// Backpressure: the owner holds the grant until done, withdrawal or MAX_HOLD cycles,
//   then a fixed one-cycle idle gap follows.
//
// Ports:
//   clk      rising-edge clock
//   resetn   asynchronous active-low reset
//   req      per-requester request, req[i] belongs to requester i
//   done     owner releases its grant (only looked at while granting)
//   gnt_idx  granted index, drives decoder w[3:0]; holds last value while idle
//   gnt_en   grant valid, drives decoder enable e
//   gnt_oh   registered one-hot copy of the grant
//   expired  one-cycle pulse when a grant ends purely on the tenure limit
module rr_decode_scheduler #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] req,
  input  logic        done,
  output logic [3:0]  gnt_idx,
  output logic        gnt_en,
  output logic [15:0] gnt_oh,
  output logic        expired
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // tenure counts from 0 at the grant edge, so hitting LAST means MAX_HOLD cycles held
  localparam logic [7:0] LAST = 8'(MAX_HOLD - 1);

  state_t      state, state_nxt;
  logic [3:0]  ptr, ptr_nxt;
  logic [7:0]  tenure, tenure_nxt;
  logic [3:0]  idx_nxt;
  logic        en_nxt;
  logic [15:0] oh_nxt;
  logic        exp_nxt;

  logic        win_vld;
  logic [3:0]  win_idx;
  logic [3:0]  cand;
  logic        withdraw;
  logic        limit;

  // Rotating priority search starting at ptr. Walking offsets from high to low
  // lets the smallest offset (closest to ptr) be the last, and winning, write.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr;
    cand    = '0;
    for (int k = 15; k >= 0; k--) begin
      cand = ptr + 4'(k);
      if (req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign withdraw = ~req[gnt_idx];
  assign limit    = (tenure == LAST);

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    tenure_nxt = tenure;
    idx_nxt    = gnt_idx;
    en_nxt     = gnt_en;
    oh_nxt     = gnt_oh;
    exp_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          idx_nxt    = win_idx;
          en_nxt     = 1'b1;
          oh_nxt     = 16'(1) << win_idx;
          tenure_nxt = '0;
          state_nxt  = GRANT;
        end
      end
      GRANT: begin
        if (done || withdraw || limit) begin
          en_nxt    = 1'b0;
          oh_nxt    = '0;
          ptr_nxt   = gnt_idx + 4'd1;
          state_nxt = IDLE;
          // expiry is reported only when the limit alone ended the grant
          exp_nxt   = limit & ~done & ~withdraw;
        end else begin
          tenure_nxt = tenure + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      ptr     <= '0;
      tenure  <= '0;
      gnt_idx <= '0;
      gnt_en  <= 1'b0;
      gnt_oh  <= '0;
      expired <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      tenure  <= tenure_nxt;
      gnt_idx <= idx_nxt;
      gnt_en  <= en_nxt;
      gnt_oh  <= oh_nxt;
      expired <= exp_nxt;
    end
  end

endmodule

// File: tb/tb_rr_decode_scheduler.sv
module tb_rr_decode_scheduler;

  logic        clk;
  logic        resetn;
  logic [15:0] req;
  logic        done;

  logic [3:0]  gnt_idx0, gnt_idx1;
  logic        gnt_en0, gnt_en1;
  logic [15:0] gnt_oh0, gnt_oh1;
  logic        expired0, expired1;

  int checks = 0;
  int errors = 0;

  // model state: [0] tracks the MAX_HOLD=8 instance, [1] the MAX_HOLD=1 instance
  int lim[2] = '{8, 1};
  int m_en[2];
  int m_idx[2];
  int m_ptr[2];
  int m_held[2];
  int m_exp[2];

  rr_decode_scheduler #(.MAX_HOLD(8)) dut (
    .clk(clk), .resetn(resetn), .req(req), .done(done),
    .gnt_idx(gnt_idx0), .gnt_en(gnt_en0), .gnt_oh(gnt_oh0), .expired(expired0)
  );

  rr_decode_scheduler #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .resetn(resetn), .req(req), .done(done),
    .gnt_idx(gnt_idx1), .gnt_en(gnt_en1), .gnt_oh(gnt_oh1), .expired(expired1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_en[j] = 0; m_idx[j] = 0; m_ptr[j] = 0; m_held[j] = 0; m_exp[j] = 0;
    end
  endtask

  // Advance the model over the next rising edge using the inputs that edge will see.
  task automatic model_step();
    int w;
    bit d, wd, hit;
    for (int j = 0; j < 2; j++) begin
      if (m_en[j] == 0) begin
        m_exp[j] = 0;
        if (req != 16'h0) begin
          w = -1;
          for (int k = 0; k < 16; k++)
            if (w < 0 && req[(m_ptr[j] + k) % 16]) w = (m_ptr[j] + k) % 16;
          m_idx[j] = w; m_en[j] = 1; m_held[j] = 1;
        end
      end else begin
        d   = done;
        wd  = !req[m_idx[j]];
        hit = (m_held[j] >= lim[j]);
        if (d || wd || hit) begin
          m_en[j]  = 0;
          m_ptr[j] = (m_idx[j] + 1) % 16;
          m_exp[j] = (hit && !d && !wd) ? 1 : 0;
        end else begin
          m_held[j]++;
          m_exp[j] = 0;
        end
      end
    end
  endtask

  // Compare on the falling edge; inputs change 2 time units after the rising edge,
  // so what is visible here is exactly what the next rising edge will sample.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!resetn) model_reset();
      chk("en0",  int'(gnt_en0),  m_en[0]);
      chk("idx0", int'(gnt_idx0), m_idx[0]);
      chk("oh0",  int'(gnt_oh0),  m_en[0] ? (1 << m_idx[0]) : 0);
      chk("exp0", int'(expired0), m_exp[0]);
      chk("en1",  int'(gnt_en1),  m_en[1]);
      chk("idx1", int'(gnt_idx1), m_idx[1]);
      chk("oh1",  int'(gnt_oh1),  m_en[1] ? (1 << m_idx[1]) : 0);
      chk("exp1", int'(expired1), m_exp[1]);
      if (resetn) model_step();
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0; req = '0; done = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(1);
  endtask

  task automatic wait_en();
    int n;
    n = 0;
    while (!gnt_en0 && n < 40) begin
      tick(1);
      n++;
    end
    if (!gnt_en0) chk("grant_timeout", 0, 1);
  endtask

  int seq[$];
  int cnt;

  initial begin
    resetn = 1'b0; req = '0; done = 1'b0;
    tick(2);
    chk("rst_en",  int'(gnt_en0),  0);
    chk("rst_idx", int'(gnt_idx0), 0);
    chk("rst_oh",  int'(gnt_oh0),  0);
    chk("rst_exp", int'(expired0), 0);
    resetn = 1'b1;
    tick(1);

    // 1: single-cycle request to requester 0, then withdrawal
    req = 16'h0001;
    tick(1);
    chk("t1_en",  int'(gnt_en0),  1);
    chk("t1_idx", int'(gnt_idx0), 0);
    chk("t1_oh",  int'(gnt_oh0),  16'h0001);
    req = 16'h0000;
    tick(1);
    chk("t1_rel", int'(gnt_en0), 0);
    chk("t1_hold_idx", int'(gnt_idx0), 0);
    tick(2);

    // 2: all requesting, done on the second grant cycle: strict rotation
    do_reset();
    req = 16'hFFFF;
    seq.delete();
    for (int g = 0; g < 17; g++) begin
      wait_en();
      seq.push_back(int'(gnt_idx0));
      tick(1);
      done = 1'b1;
      tick(1);
      done = 1'b0;
      chk("t2_gap", int'(gnt_en0), 0);
    end
    for (int g = 0; g < 17; g++) chk("t2_seq", seq[g], g % 16);
    req = '0;
    tick(2);

    // 3: tenure limit with a steady single requester
    do_reset();
    req = 16'h0008;
    wait_en();
    cnt = 0;
    while (gnt_en0 && cnt < 20) begin
      cnt++;
      tick(1);
    end
    chk("t3_len", cnt, 8);
    chk("t3_exp", int'(expired0), 1);
    tick(1);
    chk("t3_exp_clr", int'(expired0), 0);
    chk("t3_regrant", int'(gnt_en0), 1);
    chk("t3_idx", int'(gnt_idx0), 3);
    req = '0;
    tick(2);

    // 4: wrap from 15 back to 0
    do_reset();
    req = 16'h4000;
    wait_en();
    chk("t4_first", int'(gnt_idx0), 14);
    req = 16'h0000;
    tick(2);
    req = 16'h8001;
    wait_en();
    chk("t4_own15", int'(gnt_idx0), 15);
    done = 1'b1; tick(1); done = 1'b0;
    wait_en();
    chk("t4_wrap0", int'(gnt_idx0), 0);
    done = 1'b1; tick(1); done = 1'b0;
    wait_en();
    chk("t4_back15", int'(gnt_idx0), 15);
    req = '0;
    tick(2);

    // 5: asynchronous reset in the middle of a grant
    do_reset();
    req = 16'h0020;
    wait_en();
    chk("t5_idx", int'(gnt_idx0), 5);
    tick(1);
    resetn = 1'b0;
    #1;
    chk("t5_async_en", int'(gnt_en0), 0);
    chk("t5_async_oh", int'(gnt_oh0), 0);
    tick(1);
    resetn = 1'b1;
    wait_en();
    chk("t5_regrant", int'(gnt_idx0), 5);
    req = '0;
    tick(2);

    // 6: other requesters toggling during a grant, done while idle
    do_reset();
    req = 16'h0004;
    wait_en();
    for (int c = 0; c < 5; c++) begin
      req = req ^ 16'h0200;
      tick(1);
      chk("t6_en", int'(gnt_en0), 1);
      chk("t6_idx", int'(gnt_idx0), 2);
    end
    req = '0;
    tick(1);
    chk("t6_rel", int'(gnt_en0), 0);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    chk("t6_idle_done", int'(gnt_en0), 0);
    tick(1);
    chk("t6_idle_done2", int'(gnt_en0), 0);

    // randomized traffic, including occasional resets
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: req = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
        3, 4:    req = 16'($urandom);
        5:       req = '0;
        default: req = req;
      endcase
      done   = ($urandom_range(0, 3) == 0);
      resetn = ($urandom_range(0, 399) != 0);
      tick(1);
    end
    resetn = 1'b1;
    req = '0;
    done = 1'b0;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
